// File: rtl/demux1to2_stream.sv
// rtl/demux1to2_stream.sv - registered 1-to-2 valid/ready stream demultiplexer
// Each beat is steered by in_sel into a one-entry output slot; per-port delivered-beat counters.
module demux1to2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             out0_valid_q, out0_valid_d;
  logic             out1_valid_q, out1_valid_d;
  logic [WIDTH-1:0] out0_data_q, out0_data_d;
  logic [WIDTH-1:0] out1_data_q, out1_data_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic free0, free1;
  logic accept0, accept1;
  logic deliver0, deliver1;

  always_comb begin
    // A slot is free when empty or being drained this cycle, so drain and refill overlap.
    free0    = !out0_valid_q || out0_ready;
    free1    = !out1_valid_q || out1_ready;
    in_ready = in_sel ? free1 : free0;

    accept0  = in_valid && in_ready && !in_sel;
    accept1  = in_valid && in_ready && in_sel;
    deliver0 = out0_valid_q && out0_ready;
    deliver1 = out1_valid_q && out1_ready;

    out0_valid_d = out0_valid_q;
    out0_data_d  = out0_data_q;
    if (accept0) begin
      out0_valid_d = 1'b1;
      out0_data_d  = in_data;
    end else if (deliver0) begin
      out0_valid_d = 1'b0;
    end

    out1_valid_d = out1_valid_q;
    out1_data_d  = out1_data_q;
    if (accept1) begin
      out1_valid_d = 1'b1;
      out1_data_d  = in_data;
    end else if (deliver1) begin
      out1_valid_d = 1'b0;
    end

    cnt0_d = deliver0 ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d = deliver1 ? cnt1_q + CNT_W'(1) : cnt1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out1_data_q  <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux1to2_stream.sv
// tb/tb_demux1to2_stream.sv - vector-table and sequence bench for demux1to2_stream
// A second instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_demux1to2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_sel, in_valid;
  logic       out0_ready, out1_ready;

  logic       in_ready, out0_valid, out1_valid;
  logic [7:0] out0_data, out1_data, cnt0, cnt1;

  logic       w_in_ready, w_out0_valid, w_out1_valid;
  logic [7:0] w_out0_data, w_out1_data;
  logic [1:0] w_cnt0, w_cnt1;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  demux1to2_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  demux1to2_stream #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(w_in_ready), .out0_data(w_out0_data), .out0_valid(w_out0_valid), .out0_ready(out0_ready),
    .out1_data(w_out1_data), .out1_valid(w_out1_valid), .out1_ready(out1_ready),
    .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  typedef struct {
    logic       iv;
    logic       sel;
    logic [7:0] data;
    logic       r0;
    logic       r1;
    logic       ir;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic iv, input logic sel, input logic [7:0] data,
                              input logic r0, input logic r1, input logic ir,
                              input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1,
                              input logic [7:0] c0, input logic [7:0] c1);
    vec_t v;
    v.iv = iv; v.sel = sel; v.data = data; v.r0 = r0; v.r1 = r1; v.ir = ir;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic sel, input logic [7:0] data,
                       input logic r0, input logic r1);
    @(negedge clk);
    in_valid = iv; in_sel = sel; in_data = data; out0_ready = r0; out1_ready = r1;
    #1;
  endtask

  // Producer-side protocol: data/sel must stay put while a beat is stalled.
  logic       pv_stall = 1'b0;
  logic [7:0] pv_data;
  logic       pv_sel;
  always @(posedge clk) begin
    if (rst_n && pv_stall && (in_data !== pv_data || in_sel !== pv_sel)) begin
      n_mis++;
      $display("FAIL protocol: stalled beat changed to 0x%0h/%0b from 0x%0h/%0b",
               in_data, in_sel, pv_data, pv_sel);
    end
    pv_stall <= rst_n && in_valid && !in_ready;
    pv_data  <= in_data;
    pv_sel   <= in_sel;
  end

  logic [7:0] sb[16];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #12 rst_n = 1'b1;

    // T1: load both slots, then async reset mid-cycle
    drive(1, 0, 8'h10, 1, 0);
    drive(1, 1, 8'hDD, 1, 0);
    drive(1, 0, 8'hEE, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    chk("t1.pre_v0", out0_valid, 1);
    chk("t1.pre_v1", out1_valid, 1);
    chk("t1.pre_cnt0", cnt0, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1.v0", out0_valid, 0);
    chk("t1.v1", out1_valid, 0);
    chk("t1.d0", out0_data, 0);
    chk("t1.d1", out1_data, 0);
    chk("t1.cnt0", cnt0, 0);
    chk("t1.cnt1", cnt1, 0);
    chk("t1.ready_sel0", in_ready, 1);
    in_sel = 1'b1; #1;
    chk("t1.ready_sel1", in_ready, 1);
    in_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // T2 routing, T3 backpressure, T4 head-of-line, then independent drains
    //            iv sel data   r0 r1 | ir v0 d0     v1 d1     c0 c1
    vecs[0]  = mk(1, 0, 8'hA5, 1, 1,   1, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 1, 8'h3C, 1, 1,   1, 1, 8'hA5, 0, 8'h00, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 1, 1,   1, 0, 8'hA5, 1, 8'h3C, 1, 0);
    vecs[3]  = mk(0, 0, 8'h00, 1, 1,   1, 0, 8'hA5, 0, 8'h3C, 1, 1);
    vecs[4]  = mk(1, 0, 8'h11, 0, 1,   1, 0, 8'hA5, 0, 8'h3C, 1, 1);
    vecs[5]  = mk(1, 0, 8'h22, 0, 1,   0, 1, 8'h11, 0, 8'h3C, 1, 1);
    vecs[6]  = mk(1, 0, 8'h22, 0, 1,   0, 1, 8'h11, 0, 8'h3C, 1, 1);
    vecs[7]  = mk(1, 0, 8'h22, 1, 1,   1, 1, 8'h11, 0, 8'h3C, 1, 1);
    vecs[8]  = mk(0, 0, 8'h00, 0, 1,   0, 1, 8'h22, 0, 8'h3C, 2, 1);
    vecs[9]  = mk(0, 0, 8'h00, 1, 1,   1, 1, 8'h22, 0, 8'h3C, 2, 1);
    vecs[10] = mk(0, 1, 8'h00, 1, 1,   1, 0, 8'h22, 0, 8'h3C, 3, 1);
    vecs[11] = mk(1, 1, 8'h5A, 1, 0,   1, 0, 8'h22, 0, 8'h3C, 3, 1);
    vecs[12] = mk(0, 1, 8'h00, 1, 0,   0, 0, 8'h22, 1, 8'h5A, 3, 1);
    vecs[13] = mk(0, 0, 8'h00, 1, 0,   1, 0, 8'h22, 1, 8'h5A, 3, 1);
    vecs[14] = mk(1, 0, 8'h77, 1, 0,   1, 0, 8'h22, 1, 8'h5A, 3, 1);
    vecs[15] = mk(0, 0, 8'h00, 1, 1,   1, 1, 8'h77, 1, 8'h5A, 3, 1);
    vecs[16] = mk(0, 0, 8'h00, 1, 1,   1, 0, 8'h77, 0, 8'h5A, 4, 2);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].iv, vecs[i].sel, vecs[i].data, vecs[i].r0, vecs[i].r1);
      chk($sformatf("v%0d.in_ready", i), in_ready, vecs[i].ir);
      chk($sformatf("v%0d.out0_valid", i), out0_valid, vecs[i].v0);
      chk($sformatf("v%0d.out0_data", i), out0_data, vecs[i].d0);
      chk($sformatf("v%0d.out1_valid", i), out1_valid, vecs[i].v1);
      chk($sformatf("v%0d.out1_data", i), out1_data, vecs[i].d1);
      chk($sformatf("v%0d.cnt0", i), cnt0, vecs[i].c0);
      chk($sformatf("v%0d.cnt1", i), cnt1, vecs[i].c1);
    end

    // T5: 16 alternating beats, no bubbles
    drive(0, 0, 8'h00, 1, 1);
    rst_n = 1'b0; #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) sb[i] = 8'h40 + 8'(i * 3);
    for (int i = 0; i < 16; i++) begin
      drive(1, i[0], sb[i], 1, 1);
      chk($sformatf("t5.in_ready%0d", i), in_ready, 1);
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          chk($sformatf("t5.v0_%0d", i), out0_valid, 1);
          chk($sformatf("t5.d0_%0d", i), out0_data, sb[i-1]);
          chk($sformatf("t5.v1_%0d", i), out1_valid, 0);
        end else begin
          chk($sformatf("t5.v1_%0d", i), out1_valid, 1);
          chk($sformatf("t5.d1_%0d", i), out1_data, sb[i-1]);
          chk($sformatf("t5.v0_%0d", i), out0_valid, 0);
        end
      end
    end
    drive(0, 0, 8'h00, 1, 1);
    chk("t5.v1_last", out1_valid, 1);
    chk("t5.d1_last", out1_data, sb[15]);
    drive(0, 0, 8'h00, 1, 1);
    chk("t5.cnt0", cnt0, 8);
    chk("t5.cnt1", cnt1, 8);
    chk("t5.v0_end", out0_valid, 0);
    chk("t5.v1_end", out1_valid, 0);

    // T6: counter wrap on the 2-bit instance, then reset with a beat buffered
    rst_n = 1'b0; #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1, 1, 8'hB0 + 8'(i), 1, 1);
    drive(0, 0, 8'h00, 1, 1);
    drive(0, 0, 8'h00, 1, 1);
    chk("t6.cnt1_w", {6'b0, w_cnt1}, 1);
    chk("t6.cnt1", cnt1, 5);
    chk("t6.cnt0_w", {6'b0, w_cnt0}, 0);
    drive(1, 1, 8'h99, 1, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk("t6.buf_v1", w_out1_valid, 1);
    chk("t6.buf_d1", w_out1_data, 8'h99);
    #3 rst_n = 1'b0;
    #1;
    chk("t6.rst_v1_w", w_out1_valid, 0);
    chk("t6.rst_cnt1_w", {6'b0, w_cnt1}, 0);
    chk("t6.rst_v1", out1_valid, 0);
    chk("t6.rst_cnt1", cnt1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 8'h00, 1, 1);
      chk($sformatf("t6.post_v1_%0d", i), w_out1_valid, 0);
      chk($sformatf("t6.post_cnt1_w_%0d", i), {6'b0, w_cnt1}, 0);
      chk($sformatf("t6.post_cnt1_%0d", i), cnt1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
